// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - registered ALU control decode with valid/ready slot and mult/div busy interlock
module alu_control_seq #(
  parameter bit EXT_FUNC = 1'b1,
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] alu_op,
  input  logic [5:0] func_code,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] alu_ctl,
  output logic       out_illegal,
  output logic       out_md,
  output logic       out_hilo,
  output logic       out_hi_sel,
  output logic       md_start,
  output logic [1:0] md_op,
  output logic       md_busy,
  output logic       md_done
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW = $clog2(MAX_LAT) + 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [3:0]    alu_ctl_q, alu_ctl_d;
  logic          ill_q, ill_d;
  logic          md_q, md_d;
  logic          hilo_q, hilo_d;
  logic          hi_q, hi_d;
  logic          md_start_q, md_start_d;
  logic [1:0]    md_op_q, md_op_d;
  logic          md_done_q, md_done_d;

  logic [3:0] dec_ctl;
  logic       dec_ill, dec_md, dec_hilo, dec_hi;
  logic       slot_free, hazard, accept;

  always_comb begin
    dec_ctl  = 4'b1111;
    dec_ill  = 1'b0;
    dec_md   = 1'b0;
    dec_hilo = 1'b0;
    dec_hi   = 1'b0;
    case (alu_op)
      2'b00: dec_ctl = 4'b0010;
      2'b01: dec_ctl = 4'b0110;
      2'b11: dec_ill = 1'b1;
      default: begin
        case (func_code)
          6'b100000: dec_ctl = 4'b0010;
          6'b100010: dec_ctl = 4'b0110;
          6'b100100: dec_ctl = 4'b0000;
          6'b100101: dec_ctl = 4'b0001;
          6'b101010: dec_ctl = 4'b0111;
          // Extended set collapses to the illegal encoding when disabled.
          6'b100001: begin dec_ctl = EXT_FUNC ? 4'b0010 : 4'b1111; dec_ill = !EXT_FUNC; end
          6'b100011: begin dec_ctl = EXT_FUNC ? 4'b0110 : 4'b1111; dec_ill = !EXT_FUNC; end
          6'b100110: begin dec_ctl = EXT_FUNC ? 4'b0011 : 4'b1111; dec_ill = !EXT_FUNC; end
          6'b100111: begin dec_ctl = EXT_FUNC ? 4'b1100 : 4'b1111; dec_ill = !EXT_FUNC; end
          6'b101011: begin dec_ctl = EXT_FUNC ? 4'b1000 : 4'b1111; dec_ill = !EXT_FUNC; end
          6'b011000, 6'b011001, 6'b011010, 6'b011011: dec_md = 1'b1;
          6'b010000: begin dec_ctl = 4'b1110; dec_hilo = 1'b1; dec_hi = 1'b1; end
          6'b010010: begin dec_ctl = 4'b1110; dec_hilo = 1'b1; end
          default:   dec_ill = 1'b1;
        endcase
      end
    endcase
  end

  assign slot_free = !out_valid_q || out_ready;
  assign hazard    = dec_md || dec_hilo;
  assign in_ready  = slot_free && !((state_q == S_BUSY) && hazard);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    alu_ctl_d   = alu_ctl_q;
    ill_d       = ill_q;
    md_d        = md_q;
    hilo_d      = hilo_q;
    hi_d        = hi_q;
    md_start_d  = 1'b0;
    md_op_d     = md_op_q;
    md_done_d   = 1'b0;
    if (slot_free) begin
      out_valid_d = accept;
      if (accept) begin
        alu_ctl_d = dec_ctl;
        ill_d     = dec_ill;
        md_d      = dec_md;
        hilo_d    = dec_hilo;
        hi_d      = dec_hi;
      end
    end
    // The counter only loads from IDLE, so it can never wrap mid-operation.
    case (state_q)
      S_IDLE: begin
        if (accept && dec_md) begin
          state_d    = S_BUSY;
          cnt_d      = func_code[1] ? DIV_LOAD : MUL_LOAD;
          md_start_d = 1'b1;
          md_op_d    = func_code[1:0];
        end
      end
      default: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d   = S_IDLE;
          md_done_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      alu_ctl_q   <= 4'b0000;
      ill_q       <= 1'b0;
      md_q        <= 1'b0;
      hilo_q      <= 1'b0;
      hi_q        <= 1'b0;
      md_start_q  <= 1'b0;
      md_op_q     <= 2'b00;
      md_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      alu_ctl_q   <= alu_ctl_d;
      ill_q       <= ill_d;
      md_q        <= md_d;
      hilo_q      <= hilo_d;
      hi_q        <= hi_d;
      md_start_q  <= md_start_d;
      md_op_q     <= md_op_d;
      md_done_q   <= md_done_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_ctl     = alu_ctl_q;
  assign out_illegal = ill_q;
  assign out_md      = md_q;
  assign out_hilo    = hilo_q;
  assign out_hi_sel  = hi_q;
  assign md_start    = md_start_q;
  assign md_op       = md_op_q;
  assign md_busy     = (state_q == S_BUSY);
  assign md_done     = md_done_q;

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
Parametrised, registered ALU control stage with a valid/ready handshake and a multicycle mult/div interlock. It decodes ALUOp/FuncCode into a 4-bit ALU control word, extends the base function set, and issues start commands to an external HI/LO multiply/divide unit. It stalls HI/LO-dependent ops while that unit is busy. It sits between instruction decode and the ALU/MD datapath.

Parameters:
EXT_FUNC, 1, 1 enables extended functions (nor/xor/addu/subu/sltu); 0 decodes them as illegal
MUL_LAT, 4, busy cycles for mult/multu (>=1)
DIV_LAT, 32, busy cycles for div/divu (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream op valid
in_ready  out  1  combinational; op accepted on an edge where in_valid && in_ready
alu_op  in  2  ALUOp
func_code  in  6  R-type funct
out_valid  out  1  output token valid
out_ready  in  1  downstream accepts token
alu_ctl  out  4  decoded ALU control
out_illegal  out  1  unsupported encoding
out_md  out  1  token is a mult/div issue
out_hilo  out  1  token is mfhi/mflo
out_hi_sel  out  1  1=mfhi, 0=mflo (valid with out_hilo)
md_start  out  1  one-cycle start pulse to the MD unit
md_op  out  2  funct[1:0] of the issued MD op (00 mult, 01 multu, 10 div, 11 divu)
md_busy  out  1  MD unit is running
md_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0): out_valid=0, alu_ctl=0000, all flags 0, md_start=0, md_op=00, md_busy=0, md_done=0, state=IDLE, counter=0. Reset takes effect immediately, including mid-busy. No md_done is issued for an aborted op.
- Decode:
  - ALUOp 00 -> 0010.
  - ALUOp 01 -> 0110.
  - ALUOp 11 -> 1111, illegal.
  - ALUOp 10, base funct: 100000 -> 0010; 100010 -> 0110; 100100 -> 0000; 100101 -> 0001; 101010 -> 0111.
  - ALUOp 10, EXT_FUNC=1: 100001 -> 0010; 100011 -> 0110; 100110 -> 0011; 100111 -> 1100; 101011 -> 1000.
  - ALUOp 10, MD ops: 011000/011001/011010/011011 -> 1111, out_md=1.
  - ALUOp 10, HI/LO moves: 010000 -> 1110, out_hilo=1, hi_sel=1; 010010 -> 1110, out_hilo=1, hi_sel=0.
  - Any other funct -> 1111, illegal=1.
- Output register: a single slot. An accepted op appears on the outputs one cycle after the accept edge (latency 1).
  - slot_free = !out_valid || out_ready.
  - While out_valid && !out_ready, all out_* fields hold stable.
- in_ready = slot_free && !(busy && hazard), where hazard = decoded MD op or mfhi/mflo. Non-hazard ops pass during busy.
- State machine: IDLE and BUSY.
  - IDLE -> BUSY on acceptance of an MD op. The counter loads LAT-1 (MUL_LAT for func[1]=0, DIV_LAT otherwise). md_start=1 and md_op are valid in the cycle after the accept edge.
  - BUSY: each edge with counter!=0 decrements it. An edge with counter==0 returns to IDLE and sets md_done=1 for the next cycle.
  - md_busy=1 exactly for LAT cycles. A hazard op can be accepted at the end of the md_done cycle at the earliest.
- The counter runs independently of output backpressure. md_done fires even if the output slot is stalled.
- Counter width = clog2(max(MUL_LAT, DIV_LAT)) + 1. No wrap: the counter is loaded only from IDLE.
- A second MD op can never be accepted while BUSY. Reset asserted in the md_done cycle clears md_done.

Test Plan:
1. Reset, then ALUOp=10, func 100000/100010/100100/100101/101010 back-to-back with out_ready=1 -> alu_ctl 0010/0110/0000/0001/0111 each one cycle after accept, illegal=0. ALUOp 00 -> 0010; ALUOp 01 -> 0110.
2. ALUOp=10, func 000111 -> 1111, illegal=1. ALUOp=11 -> 1111, illegal=1. EXT_FUNC=0 with 100111 -> illegal=1; EXT_FUNC=1 with 100111 -> 1100, illegal=0.
3. out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, alu_ctl/flags stable. The held op is accepted on the edge where out_ready returns to 1.
4. MUL_LAT=4: mult (011000) -> md_start 1 cycle, md_op=00, md_busy 4 cycles. An add issued during busy passes with ctl 0010. mflo presented during busy holds in_ready=0 until the md_done cycle, is accepted at its end, and yields ctl 1110, hilo=1, hi_sel=0.
5. DIV_LAT=32: div then immediately multu -> multu stalls 32+ cycles. multu is accepted after md_done and gets a new md_start with md_op=01 and md_busy for 4 cycles.
6. div issued, rst_n low during busy cycle 10 -> md_busy, out_valid and md_done go to 0 immediately. No md_done after release. in_ready=1 and a new mfhi is accepted at the first edge after release.
